// File: rtl/banked_reg_file_if.sv
// Write/read bus of the banked register file: write request, read pointers,
// read data and bank/busy status.
interface banked_reg_file_if #(
    parameter int DW = 8,
    parameter int PW = 3,
    parameter int NB = 2
);
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    logic          wr_en;
    logic [1:0]    mode;
    logic [DW-1:0] dat_in;
    logic [PW-1:0] wr_addr;
    logic [PW-1:0] rd_addrA;
    logic [PW-1:0] rd_addrB;
    logic [DW-1:0] datA_out;
    logic [DW-1:0] datB_out;
    logic [DW-1:0] reg0;
    logic [BW-1:0] bank;
    logic          busy;

    modport master (
        output wr_en, mode, dat_in, wr_addr, rd_addrA, rd_addrB,
        input  datA_out, datB_out, reg0, bank, busy
    );

    modport slave (
        input  wr_en, mode, dat_in, wr_addr, rd_addrA, rd_addrB,
        output datA_out, datB_out, reg0, bank, busy
    );
endinterface

// File: rtl/banked_reg_file.sv
// Banked register file with accumulator/in-place/swap/bank-select writes and
// two combinational read ports on the active bank.
module banked_reg_file #(
    parameter int DW = 8,
    parameter int PW = 3,
    parameter int NB = 2
) (
    input  logic               clk,
    input  logic               reset,
    banked_reg_file_if.slave   bus
);
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int NR = 1 << PW;

    localparam logic [1:0] MODE_ACC     = 2'b00;
    localparam logic [1:0] MODE_INPLACE = 2'b01;
    localparam logic [1:0] MODE_SWAP    = 2'b10;
    localparam logic [1:0] MODE_BANKSEL = 2'b11;

    typedef enum logic {S_IDLE, S_SWAP2} state_t;

    logic [DW-1:0] regs_q [NB][NR];
    logic [DW-1:0] regs_d [NB][NR];
    logic [BW-1:0] bank_q, bank_d;
    state_t        state_q, state_d;
    logic          busy_q, busy_d;
    logic [DW-1:0] sw_val_q, sw_val_d;
    logic [BW-1:0] sw_bank_q, sw_bank_d;

    always_comb begin
        regs_d    = regs_q;
        bank_d    = bank_q;
        state_d   = state_q;
        busy_d    = 1'b0;
        sw_val_d  = sw_val_q;
        sw_bank_d = sw_bank_q;
        case (state_q)
            S_IDLE: begin
                if (bus.wr_en) begin
                    case (bus.mode)
                        MODE_ACC:     regs_d[bank_q][0] = bus.dat_in;
                        MODE_INPLACE: regs_d[bank_q][bus.wr_addr] = bus.dat_in;
                        MODE_SWAP: begin
                            regs_d[bank_q][bus.wr_addr] = bus.dat_in;
                            // Swap into register 0 degenerates to a plain ACC write.
                            if (bus.wr_addr != '0) begin
                                sw_val_d  = regs_q[bank_q][bus.wr_addr];
                                sw_bank_d = bank_q;
                                state_d   = S_SWAP2;
                                busy_d    = 1'b1;
                            end
                        end
                        MODE_BANKSEL: begin
                            if (NB > 1)
                                bank_d = BW'(int'(bus.dat_in[BW-1:0]) % NB);
                        end
                        default: ;
                    endcase
                end
            end
            S_SWAP2: begin
                regs_d[sw_bank_q][0] = sw_val_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < NB; b++)
                for (int r = 0; r < NR; r++)
                    regs_q[b][r] <= '0;
            bank_q    <= '0;
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            sw_val_q  <= '0;
            sw_bank_q <= '0;
        end else begin
            regs_q    <= regs_d;
            bank_q    <= bank_d;
            state_q   <= state_d;
            busy_q    <= busy_d;
            sw_val_q  <= sw_val_d;
            sw_bank_q <= sw_bank_d;
        end
    end

    assign bus.datA_out = regs_q[bank_q][bus.rd_addrA];
    assign bus.datB_out = regs_q[bank_q][bus.rd_addrB];
    assign bus.reg0     = regs_q[bank_q][0];
    assign bus.bank     = bank_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_banked_reg_file.sv
// Directed bench for banked_reg_file: reset, write modes, bank switching,
// swap sequencing and reset abort of a swap.
`timescale 1ns/1ps
module tb_banked_reg_file;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    banked_reg_file_if #(.DW(8), .PW(3), .NB(2)) bus ();

    banked_reg_file #(.DW(8), .PW(3), .NB(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] m, input logic [2:0] a, input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.mode    = m;
        bus.wr_addr = a;
        bus.dat_in  = d;
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [2:0] b);
        bus.rd_addrA = a;
        bus.rd_addrB = b;
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        bus.wr_en    = 1'b0;
        bus.mode     = 2'b00;
        bus.dat_in   = 8'h00;
        bus.wr_addr  = 3'd0;
        bus.rd_addrA = 3'd0;
        bus.rd_addrB = 3'd0;
        step();
        step();

        for (int i = 0; i < 8; i++) begin
            rd(3'(i), 3'(7 - i));
            check($sformatf("rst_A%0d", i), 32'(bus.datA_out), 32'h0);
            check($sformatf("rst_B%0d", 7 - i), 32'(bus.datB_out), 32'h0);
        end
        check("rst_reg0", 32'(bus.reg0), 32'h0);
        check("rst_bank", 32'(bus.bank), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);

        // release between edges; first write must land on the very next edge
        step();
        reset = 1'b0;
        rd(3'd5, 3'd0);
        bus.wr_en = 1'b1; bus.mode = 2'b01; bus.wr_addr = 3'd5; bus.dat_in = 8'h3C;
        #1;
        check("no_bypass", 32'(bus.datA_out), 32'h0);
        step();
        bus.wr_en = 1'b0;
        check("inplace5", 32'(bus.datA_out), 32'h3C);
        wr(2'b00, 3'd5, 8'h11);
        rd(3'd5, 3'd0);
        check("acc_A5", 32'(bus.datA_out), 32'h3C);
        check("acc_B0", 32'(bus.datB_out), 32'h11);
        check("acc_reg0", 32'(bus.reg0), 32'h11);

        wr(2'b01, 3'd2, 8'hAA);
        wr(2'b11, 3'd0, 8'h01);
        check("banksel1", 32'(bus.bank), 32'h1);
        rd(3'd2, 3'd0);
        check("bank1_empty2", 32'(bus.datA_out), 32'h0);
        check("bank1_reg0", 32'(bus.reg0), 32'h0);
        wr(2'b01, 3'd2, 8'h55);
        rd(3'd2, 3'd5);
        check("bank1_A2", 32'(bus.datA_out), 32'h55);
        wr(2'b11, 3'd0, 8'h00);
        check("banksel0", 32'(bus.bank), 32'h0);
        rd(3'd2, 3'd5);
        check("bank0_A2", 32'(bus.datA_out), 32'hAA);
        check("bank0_B5", 32'(bus.datB_out), 32'h3C);

        wr(2'b01, 3'd3, 8'h07);
        wr(2'b10, 3'd3, 8'hF0);
        rd(3'd3, 3'd4);
        check("swap_c1_r3", 32'(bus.datA_out), 32'hF0);
        check("swap_c1_busy", 32'(bus.busy), 32'h1);
        check("swap_c1_reg0", 32'(bus.reg0), 32'h11);
        wr(2'b01, 3'd4, 8'h99);
        rd(3'd3, 3'd4);
        check("swap_c2_reg0", 32'(bus.reg0), 32'h07);
        check("swap_c2_busy", 32'(bus.busy), 32'h0);
        check("swap_drop_r4", 32'(bus.datB_out), 32'h0);

        wr(2'b01, 3'd6, 8'h42);
        wr(2'b10, 3'd6, 8'h24);
        check("swap2_busy", 32'(bus.busy), 32'h1);
        wr(2'b11, 3'd0, 8'h01);
        rd(3'd6, 3'd0);
        check("swap2_bank", 32'(bus.bank), 32'h0);
        check("swap2_reg0", 32'(bus.reg0), 32'h42);
        check("swap2_r6", 32'(bus.datA_out), 32'h24);
        step();
        check("swap2_bank_later", 32'(bus.bank), 32'h0);

        wr(2'b01, 3'd1, 8'h5A);
        wr(2'b10, 3'd1, 8'h77);
        check("abort_busy_pre", 32'(bus.busy), 32'h1);
        reset = 1'b1;
        rd(3'd1, 3'd6);
        check("abort_async_A1", 32'(bus.datA_out), 32'h0);
        check("abort_async_B6", 32'(bus.datB_out), 32'h0);
        check("abort_async_busy", 32'(bus.busy), 32'h0);
        step();
        reset = 1'b0;
        step();
        step();
        check("abort_reg0", 32'(bus.reg0), 32'h0);
        check("abort_busy", 32'(bus.busy), 32'h0);

        wr(2'b10, 3'd0, 8'h33);
        check("swap0_reg0", 32'(bus.reg0), 32'h33);
        check("swap0_busy", 32'(bus.busy), 32'h0);
        step();
        check("swap0_busy_next", 32'(bus.busy), 32'h0);
        check("swap0_reg0_next", 32'(bus.reg0), 32'h33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
